// File: rtl/ms_slave_arbiter.sv
// ms_slave_arbiter: round-robin arbiter sharing one slave port among NUM_REQ requesters, with acceptance watchdog
module ms_slave_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*DATA_W-1:0]  m_in,
  input  logic [NUM_REQ-1:0]         m_in_sync,
  output logic [NUM_REQ-1:0]         m_in_notify,
  output logic [DATA_W-1:0]          s_out,
  output logic                       s_out_notify,
  input  logic                       s_out_sync,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {section_idle, section_transfer} state_t;
  state_t state, state_n;
  logic [GW-1:0] last_grant, last_n, grant_n, pick, j;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] s_out_n;
  logic [NUM_REQ-1:0] masked, m_notify_n;
  logic hit, notify_n, busy_n, err_n;
  // descending scan so the closest index after last_grant is the one that sticks
  always_comb begin
    masked = m_in_sync & ~m_in_notify;
    pick = '0;
    hit = 1'b0;
    j = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = GW'((int'(last_grant) + k) % NUM_REQ);
      if (masked[j]) begin
        pick = j;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    s_out_n = s_out;
    grant_n = grant_id;
    notify_n = s_out_notify;
    busy_n = busy;
    err_n = 1'b0;
    m_notify_n = '0;
    last_n = last_grant;
    cnt_n = cnt;
    if (state == section_idle) begin
      if (hit) begin
        s_out_n = m_in[int'(pick)*DATA_W +: DATA_W];
        grant_n = pick;
        notify_n = 1'b1;
        busy_n = 1'b1;
        cnt_n = '0;
        state_n = section_transfer;
      end
    end else if (s_out_sync) begin
      notify_n = 1'b0;
      busy_n = 1'b0;
      m_notify_n[grant_id] = 1'b1;
      last_n = grant_id;
      state_n = section_idle;
    end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
      notify_n = 1'b0;
      busy_n = 1'b0;
      err_n = 1'b1;
      last_n = grant_id;
      state_n = section_idle;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= section_idle;
      last_grant <= GW'(NUM_REQ - 1);
      cnt <= '0;
      s_out <= '0;
      s_out_notify <= 1'b0;
      m_in_notify <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      last_grant <= last_n;
      cnt <= cnt_n;
      s_out <= s_out_n;
      s_out_notify <= notify_n;
      m_in_notify <= m_notify_n;
      grant_id <= grant_n;
      busy <= busy_n;
      err_timeout <= err_n;
    end
  end
endmodule

// File: tb/tb_ms_slave_arbiter.sv
// tb_ms_slave_arbiter: random requesters and slave, transaction scoreboard against a round-robin reference model
module tb_ms_slave_arbiter;
  localparam int N = 3, W = 32, T = 4;
  logic clk = 0, rst = 1;
  logic [N*W-1:0] m_in = '0;
  logic [N-1:0] m_in_sync = '0, m_in_notify;
  logic [W-1:0] s_out;
  logic s_out_notify, s_out_sync = 0, busy, err_timeout;
  logic [1:0] grant_id;
  ms_slave_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync), .m_in_notify(m_in_notify),
    .s_out(s_out), .s_out_notify(s_out_notify), .s_out_sync(s_out_sync),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int pass_n = 0, total_n = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  typedef struct {int cy; int id; logic [W-1:0] w;} offer_t;
  typedef struct {int cy; bit tmo; int id;} done_t;
  offer_t offq[$];
  done_t doneq[$];
  // reference model: who holds the slave port, for how long, and who went last
  bit mb = 0;
  int mg = 0, mlast = N - 1, mwait = 0;
  logic [N-1:0] mnot = '0;
  task automatic step(int p_req, int p_acc, int p_chg, int p_drop);
    logic [N-1:0] pend, nn;
    bit found;
    @(posedge clk);
    #1;
    chk("offer_missing", offq.size(), 0);
    chk("done_missing", doneq.size(), 0);
    offq.delete();
    doneq.delete();
    nn = '0;
    if (rst) begin
      mb = 0; mg = 0; mlast = N - 1; mnot = '0;
      chk("rst_s_out", s_out, 0);
      chk("rst_s_out_notify", s_out_notify, 0);
      chk("rst_m_in_notify", m_in_notify, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_timeout", err_timeout, 0);
    end else begin
      if (mb) begin
        if (s_out_sync) begin
          doneq.push_back('{cyc, 1'b0, mg}); nn[mg] = 1'b1; mb = 0; mlast = mg;
        end else if (mwait == T) begin
          doneq.push_back('{cyc, 1'b1, mg}); mb = 0; mlast = mg;
        end else mwait++;
      end else begin
        pend = m_in_sync & ~mnot;
        found = 0;
        for (int k = 1; k <= N; k++)
          if (!found && pend[(mlast + k) % N]) begin mg = (mlast + k) % N; found = 1; end
        if (found) begin
          offq.push_back('{cyc, mg, m_in[mg*W +: W]}); mb = 1; mwait = 1;
        end
      end
      mnot = nn;
      chk("busy", busy, mb);
      chk("s_out_notify", s_out_notify, mb);
      chk("grant_id_hold", grant_id, mg);
    end
    for (int i = 0; i < N; i++) begin
      if (!m_in_sync[i]) begin
        if ($urandom_range(99) < p_req) begin m_in_sync[i] = 1; m_in[i*W +: W] = $urandom; end
      end else if (mnot[i] && $urandom_range(99) < p_drop) m_in_sync[i] = 0;
      if ($urandom_range(99) < p_chg) m_in[i*W +: W] = $urandom;
    end
    s_out_sync = $urandom_range(99) < p_acc;
  endtask
  logic prev_n = 0;
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    offer_t o;
    done_t d;
    if (s_out_notify && !prev_n) begin
      if (offq.size() == 0) begin
        total_n++; $display("FAIL spurious_offer: got grant %0d expected none (cycle %0d)", grant_id, cyc);
      end else begin
        o = offq.pop_front();
        chk("offer_cycle", cyc, o.cy); chk("grant_id", grant_id, o.id); chk("s_out", s_out, o.w);
      end
      held = s_out;
    end else if (s_out_notify) chk("s_out_stable", s_out, held);
    if (m_in_notify != 0 || err_timeout) begin
      if (doneq.size() == 0) begin
        total_n++; $display("FAIL spurious_done: got notify %b err %b expected none (cycle %0d)", m_in_notify, err_timeout, cyc);
      end else begin
        d = doneq.pop_front();
        chk("done_cycle", cyc, d.cy);
        chk("err_timeout", err_timeout, d.tmo);
        chk("m_in_notify", m_in_notify, d.tmo ? 0 : (1 << d.id));
      end
    end
    prev_n = s_out_notify;
  end
  initial begin
    int guard;
    repeat (2) step(0, 0, 0, 0);
    rst = 0;
    m_in[1*W +: W] = 32'h1234; m_in_sync = 3'b010; s_out_sync = 1;
    repeat (4) step(0, 100, 0, 100);
    m_in_sync = '1;
    repeat (12) step(100, 100, 0, 0);
    repeat (60) step(40, 20, 50, 70);
    m_in_sync = 3'b001;
    repeat (2) step(0, 0, 30, 0);
    m_in_sync[1] = 1;
    repeat (16) step(0, 0, 30, 0);
    repeat (2000) step($urandom_range(10, 90), $urandom_range(0, 100), 30, $urandom_range(0, 100));
    guard = 0;
    while (!mb && guard < 20) begin step(100, 0, 0, 0); guard++; end
    if (!mb) begin total_n++; $display("FAIL busy_wait: got idle expected transfer within 20 cycles"); end
    rst = 1;
    step(0, 0, 0, 0);
    rst = 0;
    m_in_sync = '1;
    repeat (40) step(50, 70, 30, 50);
    repeat (T + 3) step(0, 100, 0, 100);
    chk("offq_empty", offq.size(), 0);
    chk("doneq_empty", doneq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
